// File: rtl/rom_prog_ctrl.sv
// In-system byte programmer for the 28C256/29C256-class parts in sockets SKT01/SKT23.
// Define ROM_PROG_ERASE_EN to enable the JEDEC chip-erase command list.
module rom_prog_ctrl #(
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned POLL_GAP  = 8,
    parameter int unsigned POLL_MAX  = 4095
) (
    input  logic        wclk,
    input  logic        reset_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_data,
    input  logic        req_skt,
    input  logic        req_erase,
    input  logic        cpu_rom_req,
    output logic        bus_own,
    output logic [1:0]  rom_cs_b,
    output logic        rom_we_b,
    output logic        rom_oe_b,
    output logic [14:0] rom_a,
    output logic [7:0]  rom_dout,
    input  logic [7:0]  rom_din,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_M1 = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int unsigned CNT_MX = (CNT_M1 > POLL_GAP) ? CNT_M1 : POLL_GAP;
    localparam int unsigned CNT_W  = $clog2(CNT_MX + 1);
    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
`ifdef ROM_PROG_ERASE_EN
    localparam int unsigned STEP_W = 3;
`else
    localparam int unsigned STEP_W = 2;
`endif

    typedef enum logic [3:0] {
        ST_IDLE, ST_ARB, ST_SETUP, ST_STROBE, ST_HOLD,
        ST_PGAP, ST_PRD, ST_DONE, ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                issued_q, issued_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [14:0]         addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                skt_q, skt_d;
`ifdef ROM_PROG_ERASE_EN
    logic                erase_q, erase_d;
`endif

    logic [STEP_W-1:0]   last_step;
    logic [14:0]         cmd_addr;
    logic [7:0]          cmd_data;
    logic [14:0]         poll_addr;
    logic                poll_tgt;
    logic                unused_din;

    assign unused_din = ^rom_din[6:0];

`ifdef ROM_PROG_ERASE_EN
    assign last_step = erase_q ? STEP_W'(5) : STEP_W'(3);
    assign poll_addr = erase_q ? '0 : addr_q;
    assign poll_tgt  = erase_q ? 1'b1 : data_q[7];
`else
    assign last_step = STEP_W'(3);
    assign poll_addr = addr_q;
    assign poll_tgt  = data_q[7];
`endif

    always_comb begin
        cmd_addr = 15'h5555;
        cmd_data = 8'hAA;
`ifdef ROM_PROG_ERASE_EN
        if (erase_q) begin
            case (step_q)
                STEP_W'(1): begin cmd_addr = 15'h2AAA; cmd_data = 8'h55; end
                STEP_W'(2): cmd_data = 8'h80;
                STEP_W'(4): begin cmd_addr = 15'h2AAA; cmd_data = 8'h55; end
                STEP_W'(5): cmd_data = 8'h10;
                default: ;
            endcase
        end else
`endif
        begin
            case (step_q)
                STEP_W'(1): begin cmd_addr = 15'h2AAA; cmd_data = 8'h55; end
                STEP_W'(2): cmd_data = 8'hA0;
                STEP_W'(3): begin cmd_addr = addr_q; cmd_data = data_q; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wclk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            issued_q <= 1'b0;
            cnt_q    <= '0;
            poll_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            skt_q    <= 1'b0;
`ifdef ROM_PROG_ERASE_EN
            erase_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            issued_q <= issued_d;
            cnt_q    <= cnt_d;
            poll_q   <= poll_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            skt_q    <= skt_d;
`ifdef ROM_PROG_ERASE_EN
            erase_q  <= erase_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;
        poll_d   = poll_q;
        addr_d   = addr_q;
        data_d   = data_q;
        skt_d    = skt_q;
`ifdef ROM_PROG_ERASE_EN
        erase_d  = erase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    data_d   = req_data;
                    skt_d    = req_skt;
                    step_d   = '0;
                    issued_d = 1'b0;
                    cnt_d    = '0;
                    poll_d   = '0;
`ifdef ROM_PROG_ERASE_EN
                    erase_d  = req_erase;
                    state_d  = ST_ARB;
`else
                    state_d  = req_erase ? ST_ERR : ST_ARB;
`endif
                end
            end
            ST_ARB: begin
                cnt_d = '0;
                if (!cpu_rom_req) state_d = issued_q ? ST_PGAP : ST_SETUP;
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Step index may wrap after the last step; issued_q records completion.
            ST_HOLD: begin
                step_d  = step_q + 1'b1;
                if (step_q == last_step) issued_d = 1'b1;
                state_d = ST_ARB;
            end
            ST_PGAP: begin
                if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
                    if (!cpu_rom_req) begin
                        cnt_d   = '0;
                        state_d = ST_PRD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PRD: begin
                if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (rom_din[7] == poll_tgt) begin
                        state_d = ST_DONE;
                    end else begin
                        poll_d  = poll_q + 1'b1;
                        state_d = (poll_q == POLL_W'(POLL_MAX - 1)) ? ST_ERR : ST_PGAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        done      = (state_q == ST_DONE);
        err       = (state_q == ST_ERR);
        bus_own   = 1'b0;
        rom_cs_b  = '1;
        rom_we_b  = 1'b1;
        rom_oe_b  = 1'b1;
        rom_a     = '0;
        rom_dout  = '0;
        case (state_q)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                bus_own         = 1'b1;
                rom_cs_b[skt_q] = 1'b0;
                rom_a           = cmd_addr;
                rom_dout        = cmd_data;
                rom_we_b        = (state_q != ST_STROBE);
            end
            ST_PRD: begin
                bus_own         = 1'b1;
                rom_cs_b[skt_q] = 1'b0;
                rom_a           = poll_addr;
                rom_oe_b        = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rom_prog_ctrl.md
Name: rom_prog_ctrl

Overview:
Sequences in-system byte programming of the 28C256/29C256-class parts fitted in the two ROM sockets (SKT01, SKT23).
- Issues the JEDEC software-data-protection unlock sequence, the program write, then DQ7 data-polling until complete or timed out.
- Yields the ROM bus to CPU ROM reads (CPU priority) at every bus-cycle boundary.
- Sits beside the ROM-select/chip-select decode; while it owns the bus, its outputs drive the socket pins through an external mux.

Parameters:
WE_CYCLES, 2, number of wclk cycles rom_we_b is held low per write
RD_CYCLES, 2, number of wclk cycles rom_oe_b is held low per poll read; data is sampled on the last cycle
POLL_GAP, 8, idle wclk cycles between successive poll reads
POLL_MAX, 4095, maximum poll reads before error; sets poll counter width = clog2(POLL_MAX+1)

Ports:
wclk  input  1  clock; all state changes on the rising edge
reset_b  input  1  reset, asynchronous, active-low
req_valid  input  1  program request present
req_ready  output  1  block idle; request accepted when req_valid & req_ready
req_addr  input  15  byte address within the 32K device
req_data  input  8  byte to program
req_skt  input  1  0 = SKT01, 1 = SKT23
req_erase  input  1  chip-erase request; see Optional Feature
cpu_rom_req  input  1  CPU ROM read in progress; has priority
bus_own  output  1  block drives the socket bus
rom_cs_b  output  2  socket chip selects, active-low; bit 0 = SKT01, bit 1 = SKT23
rom_we_b  output  1  write strobe, active-low
rom_oe_b  output  1  output enable, active-low
rom_a  output  15  socket address
rom_dout  output  8  write data
rom_din  input  8  socket read data
done  output  1  one-cycle pulse on successful completion
err  output  1  one-cycle pulse on timeout or rejected request

Behaviour:
- Reset (asynchronous, immediate, including mid-sequence):
  - state IDLE, bus_own=0, rom_cs_b=2'b11, rom_we_b=1, rom_oe_b=1, rom_a=0, rom_dout=0, done=0, err=0, all counters 0.
  - A program cut short by reset is abandoned; no resume.
- States: IDLE, ARB, SETUP, STROBE, HOLD, PGAP, PRD, DONE, ERR.
- req_ready=1 only in IDLE. On accept, req_addr, req_data, req_skt and req_erase are latched; step index=0; next state is ARB.
- Program command list, indexed by step 0..3:
  - step 0: AA @ 5555h
  - step 1: 55 @ 2AAAh
  - step 2: A0 @ 5555h
  - step 3: req_data @ req_addr
- ARB:
  - Waits while cpu_rom_req=1; bus_own=0 in this state.
  - When cpu_rom_req=0: if step < last, go to SETUP; if all steps are issued, go to PGAP.
- SETUP, 1 cycle:
  - bus_own=1.
  - rom_a and rom_dout set to the current step's values.
  - rom_cs_b[req_skt]=0; the other chip select stays 1.
  - rom_we_b=1, rom_oe_b=1.
- STROBE: rom_we_b=0 for WE_CYCLES cycles. Address, data and chip select are stable.
- HOLD, 1 cycle: rom_we_b=1, chip select still asserted. Then step increments, bus_own=0, go to ARB.
- Mid-step arbitration: cpu_rom_req is ignored during SETUP/STROBE/HOLD; a step is never split. Worst-case CPU wait = WE_CYCLES+2 cycles.
- PGAP: waits POLL_GAP cycles with bus released. Then goes to PRD, gated by cpu_rom_req=0 the same way as ARB.
- PRD:
  - bus_own=1, rom_a=latched addr, chip select asserted, rom_oe_b=0 for RD_CYCLES cycles.
  - On the last cycle, rom_din[7] is sampled and compared with the target bit (req_data[7] for program).
  - Match: go to DONE.
  - Mismatch: poll count increments; if count reaches POLL_MAX go to ERR, otherwise go to PGAP.
- DONE / ERR: one cycle, pulse done / err respectively, then IDLE. done and err are never asserted together.
- bus_own is 0 in IDLE, ARB, PGAP, DONE and ERR. rom_cs_b=2'b11 and rom_we_b=rom_oe_b=1 whenever bus_own=0.
- A new req_valid arriving while busy is not accepted and is held by the requester.

Optional Feature:
ROM_PROG_ERASE_EN
- Defined:
  - A request with req_erase=1 runs the 6-step chip-erase list: AA@5555, 55@2AAA, 80@5555, AA@5555, 55@2AAA, 10@5555.
  - Polling then targets DQ7=1; req_data and req_addr are ignored except that the poll address is 0000h.
  - Step index is 3 bits.
- Undefined:
  - A request with req_erase=1 is accepted, no bus cycle is issued, and err pulses one cycle later.
  - Step index is 2 bits.

Test Plan:
- Reset; then req addr=0123h, data=5Ah, skt=0, cpu_rom_req=0:
  - Writes AA@5555, 55@2AAA, A0@5555, 5A@0123 in order, each with a 2-cycle we_b low.
  - rom_cs_b=2'b10 throughout the writes.
  - The model returns DQ7=1 for 3 polls, then 0: done pulses after the 4th poll; err stays 0.
- Same request with skt=1, cpu_rom_req asserted for 10 cycles during step 1:
  - Step 1 completes; step 2 SETUP is delayed until cpu_rom_req=0.
  - bus_own=0 during the wait; rom_cs_b=2'b01 during the writes.
- Model never matches DQ7, with POLL_MAX=4 override: exactly 4 PRD reads occur, then err pulses once and req_ready=1.
- Assert reset_b low during STROBE of step 2: outputs return to reset values immediately; after release, a new request completes normally.
- req_valid held during a busy sequence: it is not accepted until IDLE and is then processed as a second full sequence.
- ROM_PROG_ERASE_EN defined, req_erase=1: issues the 6-step erase list, then polls 0000h until DQ7=1 and pulses done. Macro undefined: no bus activity and err pulses once.
